alu_rr_arbiter: RTL and testbench

//  Shares one combinational ALU between two requesters with round-robin arbitration.

---
 rtl/alu_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_rr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one external ALU between two requesters:
// registers the granted operation, waits one cycle for the ALU, then returns the result.
module alu_rr_arbiter #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [5:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [5:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [5:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_zr,
  output logic             rsp0_ng,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_zr,
  output logic             rsp1_ng
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e                  state_q;
  logic                    last_grant_q, owner_q;
  logic [WIDTH-1:0]        alu_x_q, alu_y_q;
  logic [5:0]              alu_ctrl_q;
  logic [1:0]              rsp_vld_q;
  logic [1:0][WIDTH-1:0]   rsp_data_q;
  logic [1:0]              rsp_zr_q, rsp_ng_q;

  logic [1:0]              req_v, req_rdy, rsp_rdy;
  logic [1:0][WIDTH-1:0]   req_x, req_y;
  logic [1:0][5:0]         req_c;
  logic                    grant_d;

  assign req_v   = {req1_valid, req0_valid};
  assign req_x   = {req1_x, req0_x};
  assign req_y   = {req1_y, req0_y};
  assign req_c   = {req1_ctrl, req0_ctrl};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};

  // On contention the requester that did not win last time goes next.
  always_comb begin
    grant_d = 1'b0;
    if (req_v == 2'b10)      grant_d = 1'b1;
    else if (req_v == 2'b11) grant_d = ~last_grant_q;
  end

  // rst_n gating keeps ready low while reset is asserted even if valid is held.
  always_comb begin
    req_rdy = 2'b00;
    if (rst_n && state_q == IDLE)
      req_rdy = req_v & (grant_d ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_vld_q    <= '0;
      rsp_data_q   <= '0;
      rsp_zr_q     <= '0;
      rsp_ng_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req_v) begin
          alu_x_q    <= req_x[grant_d];
          alu_y_q    <= req_y[grant_d];
          alu_ctrl_q <= req_c[grant_d];
          owner_q    <= grant_d;
          state_q    <= EXEC;
        end
        EXEC: begin
          rsp_data_q[owner_q] <= alu_out;
          rsp_zr_q[owner_q]   <= alu_zr;
          rsp_ng_q[owner_q]   <= alu_ng;
          rsp_vld_q[owner_q]  <= 1'b1;
          state_q             <= RESP;
        end
        RESP: if (rsp_rdy[owner_q]) begin
          rsp_vld_q[owner_q] <= 1'b0;
          last_grant_q       <= owner_q;
          state_q            <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = req_rdy[0];
  assign req1_ready = req_rdy[1];
  assign alu_x      = alu_x_q;
  assign alu_y      = alu_y_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp0_valid = rsp_vld_q[0];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp0_zr    = rsp_zr_q[0];
  assign rsp0_ng    = rsp_ng_q[0];
  assign rsp1_valid = rsp_vld_q[1];
  assign rsp1_data  = rsp_data_q[1];
  assign rsp1_zr    = rsp_zr_q[1];
  assign rsp1_ng    = rsp_ng_q[1];

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter with a Hack-style ALU model on the alu_* side.
module tb_alu_rr_arbiter;
  localparam int W = 17;

  logic gclk = 1'b0;
  logic grst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
  logic [5:0] req0_ctrl, req1_ctrl;
  logic [W-1:0] alu_x, alu_y, alu_out;
  logic [5:0] alu_ctrl;
  logic alu_zr, alu_ng;
  logic rsp0_valid, rsp0_ready, rsp0_zr, rsp0_ng;
  logic rsp1_valid, rsp1_ready, rsp1_zr, rsp1_ng;
  logic [W-1:0] rsp0_data, rsp1_data;

  always #5 gclk = ~gclk;

  alu_rr_arbiter #(.WIDTH(W)) dut (
    .clk(gclk), .rst_n(grst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_ctrl(req1_ctrl),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_zr(rsp0_zr), .rsp0_ng(rsp0_ng),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_zr(rsp1_zr), .rsp1_ng(rsp1_ng)
  );

  // Returns {zr, ng, out}
  function automatic logic [W+1:0] alu_f(input logic [W-1:0] x, input logic [W-1:0] y, input logic [5:0] c);
    logic [W-1:0] a, b, o;
    a = c[5] ? '0 : x;
    if (c[4]) a = ~a;
    b = c[3] ? '0 : y;
    if (c[2]) b = ~b;
    o = c[1] ? a + b : a & b;
    if (c[0]) o = ~o;
    return {(o == '0), o[W-1], o};
  endfunction

  logic [W+1:0] alu_res;
  assign alu_res = alu_f(alu_x, alu_y, alu_ctrl);
  assign {alu_zr, alu_ng, alu_out} = alu_res;

  typedef struct { logic own; logic [W-1:0] d; logic zr; logic ng; } exp_t;
  exp_t sb[$];
  logic gq[$];
  int   n_chk = 0, n_pass = 0, cyc = 0, acc_cyc = 0;
  bit   rsp_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic own, input logic [W-1:0] x, input logic [W-1:0] y, input logic [5:0] c);
    logic [W+1:0] r;
    exp_t e;
    r = alu_f(x, y, c);
    e.own = own; e.d = r[W-1:0]; e.ng = r[W]; e.zr = r[W+1];
    sb.push_back(e);
    gq.push_back(own);
    acc_cyc = cyc;
  endtask

  task automatic do_rsp(input logic n, input logic v, input logic r, input logic [W-1:0] d,
                        input logic zr, input logic ng);
    exp_t e;
    if (!v) return;
    if (!rsp_seen) begin
      rsp_seen = 1;
      chk("latency", cyc - acc_cyc, 2);
    end
    if (r) begin
      rsp_seen = 0;
      if (sb.size() == 0) chk("unexpected_rsp", {31'b0, n}, 32'hffff_ffff);
      else begin
        e = sb.pop_front();
        chk("rsp_owner", {31'b0, n}, {31'b0, e.own});
        chk("rsp_data", d, e.d);
        chk("rsp_flags", {zr, ng}, {e.zr, e.ng});
      end
    end
  endtask

  // Monitor: sampled on the falling edge; inputs only change just after the rising edge.
  always @(negedge gclk) if (grst_n) begin
    cyc++;
    if (req0_valid && req0_ready) push_exp(1'b0, req0_x, req0_y, req0_ctrl);
    if (req1_valid && req1_ready) push_exp(1'b1, req1_x, req1_y, req1_ctrl);
    if (req0_valid && req1_valid) chk("ready_excl", req0_ready & req1_ready, 0);
    if (rsp0_valid || rsp1_valid) chk("rsp_excl", rsp0_valid & rsp1_valid, 0);
    do_rsp(1'b0, rsp0_valid, rsp0_ready, rsp0_data, rsp0_zr, rsp0_ng);
    do_rsp(1'b1, rsp1_valid, rsp1_ready, rsp1_data, rsp1_zr, rsp1_ng);
  end

  task automatic issue(input logic n, input logic [W-1:0] x, input logic [W-1:0] y, input logic [5:0] c);
    if (n) begin req1_x = x; req1_y = y; req1_ctrl = c; req1_valid = 1; end
    else   begin req0_x = x; req0_y = y; req0_ctrl = c; req0_valid = 1; end
  endtask

  // Returns just after the accepting edge (FSM now in EXEC) with valid dropped.
  task automatic wait_acc(input logic n);
    bit hit = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge gclk);
      if (n ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin hit = 1; break; end
    end
    if (!hit) chk("accept_timeout", 0, 1);
    @(posedge gclk); #1;
    if (n) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin @(posedge gclk); #1; end
    chk("drain", sb.size(), 0);
  endtask

  logic [W-1:0] d0;

  initial begin
    grst_n = 0;
    req0_valid = 1; req0_x = 17'h11; req0_y = 17'h2; req0_ctrl = 6'b000010;
    req1_valid = 1; req1_x = 17'h1F0; req1_y = 17'h0F; req1_ctrl = 6'b000000;
    rsp0_ready = 1; rsp1_ready = 1;
    #12;
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_alu", {alu_x, alu_y, alu_ctrl}, 0);
    chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_zr, rsp0_ng, rsp1_zr, rsp1_ng}, 0);
    chk("rst_data", {rsp0_data, rsp1_data}, 0);

    // Contention from reset: alternating grants 0,1,0,1
    @(posedge gclk); #1; grst_n = 1;
    for (int i = 0; i < 60 && gq.size() < 4; i++) begin @(posedge gclk); #1; end
    req0_valid = 0; req1_valid = 0;
    drain();
    chk("rr_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_order", {31'b0, gq[i]}, i % 2);

    // Single op: 3 + 5
    issue(1'b0, 17'd3, 17'd5, 6'b000010);
    wait_acc(1'b0);
    chk("exec_ctrl", alu_ctrl, 6'b000010);
    chk("exec_x", alu_x, 3);
    @(posedge gclk); #1;
    chk("t1_valid", {rsp0_valid, rsp1_valid}, 2'b10);
    chk("t1_data", rsp0_data, 8);
    chk("t1_flags", {rsp0_zr, rsp0_ng}, 0);
    drain();

    // Flags: zero, all-ones, MSB set
    issue(1'b1, 17'd9, 17'd4, 6'b101010); wait_acc(1'b1); @(posedge gclk); #1;
    chk("t4_zr", {rsp1_zr, rsp1_ng, rsp1_data}, {2'b10, 17'd0});
    drain();
    issue(1'b0, 17'd3, 17'd4, 6'b111010); wait_acc(1'b0); @(posedge gclk); #1;
    chk("t4_neg1", {rsp0_zr, rsp0_ng, rsp0_data}, {2'b01, 17'h1FFFF});
    drain();
    issue(1'b0, 17'h10000, 17'd5, 6'b000010); wait_acc(1'b0); @(posedge gclk); #1;
    chk("t4_ng", {rsp0_zr, rsp0_ng, rsp0_data}, {2'b01, 17'h10005});
    drain();

    // Back-pressure on requester 1 while requester 0 waits
    rsp1_ready = 0;
    issue(1'b1, 17'd100, 17'd23, 6'b000000);
    wait_acc(1'b1);
    issue(1'b0, 17'd7, 17'd7, 6'b000010);
    @(posedge gclk); #1;
    d0 = rsp1_data;
    chk("bp_data_val", d0, 17'd100 & 17'd23);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp1_valid, 1);
      chk("bp_stable", rsp1_data, d0);
      chk("bp_req0_rdy", req0_ready, 0);
      @(posedge gclk); #1;
    end
    rsp1_ready = 1;
    @(posedge gclk); #1;
    chk("bp_release", rsp1_valid, 0);
    wait_acc(1'b0);
    drain();

    // Operand hold through EXEC and a stalled RESP
    rsp0_ready = 0;
    issue(1'b0, 17'd7, 17'd1, 6'b000010);
    wait_acc(1'b0);
    req0_x = 17'd99;
    for (int i = 0; i < 4; i++) begin
      chk("hold_x", alu_x, 7);
      @(posedge gclk); #1;
    end
    rsp0_ready = 1;
    drain();
    issue(1'b0, 17'd99, 17'd1, 6'b000010);
    wait_acc(1'b0);
    chk("hold_next", alu_x, 99);
    drain();

    // Reset mid-op in EXEC; op is dropped, req0 wins first afterwards
    issue(1'b0, 17'd1, 17'd2, 6'b000010);
    wait_acc(1'b0);
    req0_valid = 1; req1_valid = 1;
    grst_n = 0;
    #1;
    sb.delete(); gq.delete(); rsp_seen = 0;
    chk("mid_rst_ready", {req0_ready, req1_ready}, 0);
    chk("mid_rst_alu", {alu_x, alu_y, alu_ctrl}, 0);
    chk("mid_rst_rsp", {rsp0_valid, rsp1_valid, rsp0_data, rsp1_data}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge gclk); #1;
      chk("mid_rst_norsp", {rsp0_valid, rsp1_valid}, 0);
    end
    grst_n = 1;
    wait_acc(1'b0);
    req1_valid = 0;
    chk("post_rst_first", gq.size() > 0 ? {31'b0, gq[0]} : 32'hdead, 0);
    drain();
    for (int i = 0; i < 3; i++) begin @(posedge gclk); #1; end
    chk("final_idle", {rsp0_valid, rsp1_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d/%0d checks", n_pass, n_chk);
    $fatal(1);
  end
endmodule
